// File: rtl/_shift_tx8.sv
// ---------------------------------------------------------------------------
// _shift_tx8 -- parallel-in, serial-out byte transmitter
//
// Sends one byte per frame on sout:
//   start bit (0), d[0]..d[7] LSB first, [optional even parity], stop bit (1)
// Every bit is held on the line for BIT_CYCLES clock cycles.
//
// Parameters
//   BIT_CYCLES  clock cycles per serial bit, 1..255 (0 behaves as 1)
//
// Ports
//   clk      in   single clock, all state updates on its rising edge
//   reset_n  in   synchronous active-low reset
//   valid    in   byte offered on d this cycle (only looked at in IDLE)
//   d        in   [7:0] byte to transmit
//   ready    out  high when a byte can be accepted (IDLE)
//   sout     out  serial line, idles high
//   busy     out  high while a frame is on sout
//   done     out  one-cycle pulse in the final cycle of a frame
//
// Build option
//   SHIFT_TX8_PARITY_EN  when defined, an even-parity bit is inserted
//                        between d[7] and the stop bit (frame = 11 bits).
//                        When undefined the frame is 10 bits.
// ---------------------------------------------------------------------------
module _shift_tx8 #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid,
    input  logic [7:0] d,
    output logic       ready,
    output logic       sout,
    output logic       busy,
    output logic       done
);

    // A zero setting is treated as one cycle per bit.
    localparam int unsigned BC_EFF   = (BIT_CYCLES == 0) ? 1 : BIT_CYCLES;
    localparam logic [7:0]  CNT_LAST = 8'(BC_EFF - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SHIFT_TX8_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] state;
    logic [7:0] shreg;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic       bit_end;

`ifdef SHIFT_TX8_PARITY_EN
    // Parity is captured at acceptance because the shift register is
    // emptied while the data bits go out.
    logic       par;
`endif

    // Last cycle of the current bit period.
    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            shreg <= 8'h00;
            cnt   <= 8'd0;
            idx   <= 3'd0;
`ifdef SHIFT_TX8_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        shreg <= d;
`ifdef SHIFT_TX8_PARITY_EN
                        par   <= ^d;
`endif
                        cnt   <= 8'd0;
                        idx   <= 3'd0;
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        cnt   <= 8'd0;
                        idx   <= 3'd0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= 8'd0;
                        shreg <= shreg >> 1;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef SHIFT_TX8_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

`ifdef SHIFT_TX8_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt   <= 8'd0;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        cnt   <= 8'd0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    cnt   <= 8'd0;
                    idx   <= 3'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are a pure function of state, so sout drops to 0 in the first
    // cycle after acceptance.
    always_comb begin
        sout = 1'b1;
        case (state)
            S_START:  sout = 1'b0;
            S_DATA:   sout = shreg[0];
`ifdef SHIFT_TX8_PARITY_EN
            S_PARITY: sout = par;
`endif
            default:  sout = 1'b1;
        endcase
    end

    assign busy  = (state != S_IDLE);
    assign ready = ~busy;
    assign done  = (state == S_STOP) && bit_end;

endmodule

// File: tb/tb__shift_tx8.sv
// ---------------------------------------------------------------------------
// tb__shift_tx8 -- directed self-checking bench for _shift_tx8
//
// Three instances with BIT_CYCLES = 1, 4 and 0, each with its own inputs.
// Expected frames come from a small bit-position model (frame_bit).
// ---------------------------------------------------------------------------
module tb__shift_tx8;

`ifdef SHIFT_TX8_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 10 + PAR;   // bits per frame

    logic       clk;
    logic [2:0] rstn;
    logic [2:0] vld;
    logic [7:0] din [3];
    logic [2:0] rdy;
    logic [2:0] so;
    logic [2:0] bsy;
    logic [2:0] dn;

    int ncmp;
    int nfail;

    _shift_tx8 #(.BIT_CYCLES(1)) u_bc1 (
        .clk(clk), .reset_n(rstn[0]), .valid(vld[0]), .d(din[0]),
        .ready(rdy[0]), .sout(so[0]), .busy(bsy[0]), .done(dn[0]));

    _shift_tx8 #(.BIT_CYCLES(4)) u_bc4 (
        .clk(clk), .reset_n(rstn[1]), .valid(vld[1]), .d(din[1]),
        .ready(rdy[1]), .sout(so[1]), .busy(bsy[1]), .done(dn[1]));

    _shift_tx8 #(.BIT_CYCLES(0)) u_bc0 (
        .clk(clk), .reset_n(rstn[2]), .valid(vld[2]), .d(din[2]),
        .ready(rdy[2]), .sout(so[2]), .busy(bsy[2]), .done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for bit position k of the frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset held two cycles with a byte offered on every instance.
        rstn = 3'b000;
        vld  = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 8'hFF;
        tick();
        tick();
        rstn = 3'b111;
        vld  = 3'b000;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++) begin
                ncmp++;
                if (so[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0) begin
                    nfail++;
                    $display("FAIL reset inst%0d cyc%0d: sout/ready/busy/done = %b%b%b%b, required 1100",
                             i, c, so[i], rdy[i], bsy[i], dn[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_basic_a5();
        logic [9:0] ref_seq;
        ref_seq = 10'b1101001010;   // 0,1,0,1,0,0,1,0,1,1 read from bit 0 up
        din[0] = 8'hA5;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int k = 0; k < FL; k++) begin
            ncmp++;
            if (so[0] !== frame_bit(8'hA5, k) || bsy[0] !== 1'b1 || rdy[0] !== 1'b0 ||
                dn[0] !== (k == FL - 1)) begin
                nfail++;
                $display("FAIL a5 cyc%0d: sout=%b busy=%b ready=%b done=%b, required sout=%b busy=1 ready=0 done=%b",
                         k, so[0], bsy[0], rdy[0], dn[0], frame_bit(8'hA5, k), (k == FL - 1));
            end
            if (PAR == 0) begin
                ncmp++;
                if (so[0] !== ref_seq[k]) begin
                    nfail++;
                    $display("FAIL a5_seq cyc%0d: sout=%b required %b", k, so[0], ref_seq[k]);
                end
            end
            tick();
        end
        ncmp++;
        if (rdy[0] !== 1'b1 || so[0] !== 1'b1 || dn[0] !== 1'b0) begin
            nfail++;
            $display("FAIL a5_after: ready=%b sout=%b done=%b, required 1 1 0", rdy[0], so[0], dn[0]);
        end
    endtask

    task automatic test_bc4_07();
        din[1] = 8'h07;
        vld[1] = 1'b1;
        tick();
        // Offer a different byte mid-frame; it must be ignored.
        din[1] = 8'hF0;
        for (int k = 0; k < FL * 4; k++) begin
            ncmp++;
            if (so[1] !== frame_bit(8'h07, k / 4) || bsy[1] !== 1'b1 ||
                dn[1] !== (k == FL * 4 - 1)) begin
                nfail++;
                $display("FAIL bc4 cyc%0d: sout=%b busy=%b done=%b, required sout=%b busy=1 done=%b",
                         k, so[1], bsy[1], dn[1], frame_bit(8'h07, k / 4), (k == FL * 4 - 1));
            end
            if (k == FL * 4 - 2) vld[1] = 1'b0;
            tick();
        end
        ncmp++;
        if (rdy[1] !== 1'b1 || bsy[1] !== 1'b0 || so[1] !== 1'b1) begin
            nfail++;
            $display("FAIL bc4_after: ready=%b busy=%b sout=%b, required 1 0 1", rdy[1], bsy[1], so[1]);
        end
        if (PAR == 1) begin
            ncmp++;
            if (frame_bit(8'h07, 9) !== 1'b1) begin
                nfail++;
                $display("FAIL bc4_parity_model: %b required 1", frame_bit(8'h07, 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        din[0] = 8'h00;
        vld[0] = 1'b1;
        tick();
        for (int k = 0; k < FL; k++) begin
            if (k == 2) din[0] = 8'hFF;
            ncmp++;
            if (so[0] !== frame_bit(8'h00, k) || dn[0] !== (k == FL - 1)) begin
                nfail++;
                $display("FAIL b2b_f1 cyc%0d: sout=%b done=%b, required sout=%b done=%b",
                         k, so[0], dn[0], frame_bit(8'h00, k), (k == FL - 1));
            end
            tick();
        end
        ncmp++;
        if (so[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_gap: sout=%b ready=%b busy=%b, required 1 1 0", so[0], rdy[0], bsy[0]);
        end
        tick();
        vld[0] = 1'b0;
        for (int k = 0; k < FL; k++) begin
            ncmp++;
            if (so[0] !== frame_bit(8'hFF, k) || bsy[0] !== 1'b1 || dn[0] !== (k == FL - 1)) begin
                nfail++;
                $display("FAIL b2b_f2 cyc%0d: sout=%b busy=%b done=%b, required sout=%b busy=1 done=%b",
                         k, so[0], bsy[0], dn[0], frame_bit(8'hFF, k), (k == FL - 1));
            end
            tick();
        end
        ncmp++;
        if (rdy[0] !== 1'b1 || so[0] !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_end: ready=%b sout=%b, required 1 1", rdy[0], so[0]);
        end
    endtask

    task automatic test_midframe_reset();
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        // Positions 0..4: start bit then d[0]..d[3]; reset during d[3].
        for (int k = 0; k <= 4; k++) begin
            ncmp++;
            if (so[0] !== frame_bit(8'h3C, k)) begin
                nfail++;
                $display("FAIL mid_pre cyc%0d: sout=%b required %b", k, so[0], frame_bit(8'h3C, k));
            end
            if (k == 4) rstn[0] = 1'b0;
            tick();
        end
        rstn[0] = 1'b1;
        ncmp++;
        if (so[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
            nfail++;
            $display("FAIL mid_reset: sout/ready/busy/done = %b%b%b%b, required 1100",
                     so[0], rdy[0], bsy[0], dn[0]);
        end
        tick();
        ncmp++;
        if (so[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            nfail++;
            $display("FAIL mid_noresume: sout=%b busy=%b, required 1 0", so[0], bsy[0]);
        end
        din[0] = 8'h81;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int k = 0; k < FL; k++) begin
            ncmp++;
            if (so[0] !== frame_bit(8'h81, k) || dn[0] !== (k == FL - 1)) begin
                nfail++;
                $display("FAIL mid_81 cyc%0d: sout=%b done=%b, required sout=%b done=%b",
                         k, so[0], dn[0], frame_bit(8'h81, k), (k == FL - 1));
            end
            tick();
        end
        ncmp++;
        if (rdy[0] !== 1'b1) begin
            nfail++;
            $display("FAIL mid_81_after: ready=%b required 1", rdy[0]);
        end
    endtask

    task automatic test_bc0_55();
        din[2] = 8'h55;
        vld[2] = 1'b1;
        tick();
        vld[2] = 1'b0;
        for (int k = 0; k < FL; k++) begin
            ncmp++;
            if (so[2] !== frame_bit(8'h55, k) || bsy[2] !== 1'b1 || dn[2] !== (k == FL - 1)) begin
                nfail++;
                $display("FAIL bc0 cyc%0d: sout=%b busy=%b done=%b, required sout=%b busy=1 done=%b",
                         k, so[2], bsy[2], dn[2], frame_bit(8'h55, k), (k == FL - 1));
            end
            tick();
        end
        ncmp++;
        if (rdy[2] !== 1'b1 || so[2] !== 1'b1) begin
            nfail++;
            $display("FAIL bc0_after: ready=%b sout=%b, required 1 1", rdy[2], so[2]);
        end
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        rstn  = 3'b000;
        vld   = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        tick();
        test_reset();
        test_basic_a5();
        test_bc4_07();
        test_back_to_back();
        test_midframe_reset();
        test_bc0_55();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
